lms_fir_datapath: RTL and testbench
===================================

Name: lms_fir_datapath

Overview:
Forward-path companion to the 3-tap LMS coefficient updater. Accepts input samples and desired samples on a valid strobe, maintains the 3-tap delay line, and computes y = h0·x0 + h1·x1 + h2·x2 and e = d − y in Q16.16. Returns the aligned taps and the error to the updater. A mode FSM gates adaptation during delay-line fill and switches from training to decision-directed operation.

Parameters:
NB_DATA, 32, word width of all data ports (signed two's complement)
NBF_DATA, 16, fractional bits (Q16.16)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous, active-high reset; clock i_clk
i_restart  in  1  pulse: flush delay line, return FSM to FILL
i_valid  in  1  i_x / i_desired valid this cycle
i_x  in  NB_DATA  input sample
i_desired  in  NB_DATA  training reference d
i_train_len  in  16  live samples spent in TRAIN; 0 = train forever
i_h0, i_h1, i_h2  in  NB_DATA  current coefficients from the updater
o_x0, o_x1, o_x2  out  NB_DATA  taps aligned with o_error
o_error  out  NB_DATA  e, forced 0 when not live
o_y  out  NB_DATA  filter output
o_valid  out  1  o_y / o_error / o_x* valid
o_state  out  2  FSM state: FILL=0, TRAIN=1, DD=2

Behaviour:
- Reset: all outputs, taps, counters = 0; state FILL.
- Stage 1 (on i_valid): x2<=x1, x1<=x0, x0<=i_x. Latch d, a live flag (state != FILL) and a mode flag (TRAIN/DD); all travel with the sample.
- Stage 2: products h_k·x_k are 64-bit Q32.32. Drop 16 LSBs (floor) and saturate to 32 bits. Sum the three in 34 bits, then saturate to y. Error e = d_sel − y in 33 bits, then saturate.
- Saturation limits: 0x7FFF_FFFF / 0x8000_0000. Coefficients are sampled combinationally in stage 2.
- o_x0..o_x2 are stage-2 copies of the taps that produced o_y.
- Latency: i_valid in cycle n → o_valid in cycle n+2. Full throughput: one sample per cycle.
- o_error = 0 whenever o_valid=0 or the sample is not live, so updater coefficients hold. o_y and o_x* hold their last value when o_valid=0.
- FSM:
  - FILL: counts accepted samples; → TRAIN after 2 accepted. The 3rd sample is the first live one.
  - TRAIN: d_sel = d. A 16-bit counter increments per accepted live sample. → DD when count == i_train_len (i_train_len ≠ 0). Samples accepted after the transition use DD.
  - DD: d_sel = slicer(y): y >= 0 → 0x0001_0000 (+1.0); else 0xFFFF_0000 (−1.0). i_desired is ignored.
- i_restart: taps, fill count and train count = 0; state = FILL; in-flight valids cleared (o_valid=0 the next cycle). If i_restart and i_valid arrive in the same cycle, restart wins and the sample is dropped.
- i_rst during operation: identical to reset, with no residual o_valid.
- i_train_len is sampled continuously; changing it mid-TRAIN compares against the new value.

Optional Feature:
LMS_DD_EN.
- Defined: DD state and slicer present as above.
- Undefined: FSM never leaves TRAIN, i_train_len is ignored, and o_state never reads 2.

Decomposition:
- Package lms_pkg holds:
  - NB_DATA, NBF_DATA
  - ONE_Q16 = 0x0001_0000 and MINUS_ONE_Q16
  - SAT_MAX / SAT_MIN
  - state encodings ST_FILL / ST_TRAIN / ST_DD
- Reuse the existing SatTruncFP for product, sum and error saturation; no new sub-module.
- The FSM and counters stay inline.

Test Plan:
- Reset; h=(1.0,0,0); feed x=d=0x0002_0000 each cycle → first 2 outputs o_valid=1 with o_error=0. From the 3rd, o_y=0x0002_0000 and o_error=0. o_valid trails i_valid by exactly 2 cycles.
- h=(0x0000_8000,0,0), x=1.0, d=1.0 (after fill) → o_y=0x0000_8000, o_error=0x0000_8000, o_x0=0x0001_0000.
- h0=h1=h2=0x7FFF_0000, x=0x7FFF_0000 → each product saturates; o_y=0x7FFF_FFFF. d=0x8000_0000 → o_error=0x8000_0000.
- LMS_DD_EN set, i_train_len=4 → o_state=1 for 4 live samples, then 2. With h yielding y=0xFFFF_C000 (−0.25): o_error=0xFFFF_4000 (−0.75), i_desired ignored.
- i_restart and i_valid asserted together mid-stream → sample dropped, o_valid=0 next cycle, o_state=0. The next 2 outputs have o_error=0 and taps rebuilt from zero.
- i_valid gapped 1-on/2-off → o_error=0 on every idle cycle; o_y and o_x* hold; no sample lost or duplicated.

Source files
------------

// File: rtl/lms_pkg.sv
// Shared constants, Q16.16 literals and FSM encodings for the LMS forward datapath.
package lms_pkg;

    localparam int unsigned NB_DATA  = 32;
    localparam int unsigned NBF_DATA = 16;
    localparam int unsigned NB_PROD  = 2 * NB_DATA;
    localparam int unsigned NBF_PROD = 2 * NBF_DATA;
    localparam int unsigned NB_SUM   = NB_DATA + 2;
    localparam int unsigned NB_ERR   = NB_DATA + 1;
    localparam int unsigned NB_CNT   = 16;

    localparam logic [NB_DATA-1:0] ONE_Q16       = 32'h0001_0000;
    localparam logic [NB_DATA-1:0] MINUS_ONE_Q16 = 32'hFFFF_0000;
    localparam logic [NB_DATA-1:0] SAT_MAX       = 32'h7FFF_FFFF;
    localparam logic [NB_DATA-1:0] SAT_MIN       = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_TRAIN = 2'd1,
        ST_DD    = 2'd2
    } state_t;

endpackage

// File: rtl/lms_fir_datapath_sat.sv
// SatTruncFP: floor-truncate fractional LSBs of a signed fixed-point word, then
// saturate it to a narrower signed word. Purely combinational.
module SatTruncFP #(
    parameter int unsigned NB_XI  = 64,
    parameter int unsigned NBF_XI = 32,
    parameter int unsigned NB_XO  = 32,
    parameter int unsigned NBF_XO = 16
) (
    input  logic signed [NB_XI-1:0] i_data,
    output logic signed [NB_XO-1:0] o_data_c
);

    localparam int unsigned SHIFT = NBF_XI - NBF_XO;
    localparam int unsigned NB_HI = NB_XI - NB_XO + 1;

    logic signed [NB_XI-1:0] shifted;
    logic        [NB_HI-1:0] hi;

    assign shifted = i_data >>> SHIFT;
    assign hi      = shifted[NB_XI-1:NB_XO-1];

    // Value fits when every bit above the output sign bit matches it.
    always_comb begin
        o_data_c = shifted[NB_XO-1:0];
        if (!((hi == '0) || (hi == '1))) begin
            o_data_c = hi[NB_HI-1] ? {1'b1, {(NB_XO-1){1'b0}}}
                                   : {1'b0, {(NB_XO-1){1'b1}}};
        end
    end

endmodule

// File: rtl/lms_fir_datapath.sv
// 3-tap LMS forward path: delay line, Q16.16 FIR output, error and FILL/TRAIN/DD mode FSM.
// Define LMS_DD_EN to enable the decision-directed state and slicer.
module lms_fir_datapath
    import lms_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_restart,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_x,
    input  logic [NB_DATA-1:0] i_desired,
    input  logic [NB_CNT-1:0]  i_train_len,
    input  logic [NB_DATA-1:0] i_h0,
    input  logic [NB_DATA-1:0] i_h1,
    input  logic [NB_DATA-1:0] i_h2,
    output logic [NB_DATA-1:0] o_x0,
    output logic [NB_DATA-1:0] o_x1,
    output logic [NB_DATA-1:0] o_x2,
    output logic [NB_DATA-1:0] o_error,
    output logic [NB_DATA-1:0] o_y,
    output logic               o_valid,
    output logic [1:0]         o_state
);

    state_t              state;
    logic [1:0]          fill_cnt;
    logic [NB_CNT-1:0]   train_cnt;
    logic [NB_CNT-1:0]   train_nxt_c;
    logic [NB_DATA-1:0]  x0, x1, x2, d_s1;
    logic                live_s1, valid_s1;
`ifdef LMS_DD_EN
    logic                mode_dd_s1;
`else
    logic                unused_train_len;
    assign unused_train_len = ^i_train_len;
`endif

    logic signed [NB_PROD-1:0] prod0_c, prod1_c, prod2_c;
    logic signed [NB_DATA-1:0] p0_c, p1_c, p2_c, y_c, err_sat_c;
    logic signed [NB_SUM-1:0]  sum_c;
    logic signed [NB_ERR-1:0]  err_c;
    logic        [NB_DATA-1:0] d_sel_c;

    assign train_nxt_c = train_cnt + NB_CNT'(i_valid);
    assign o_state     = state;

    // Stage-2 arithmetic on the stage-1 taps with live coefficients.
    assign prod0_c = NB_PROD'($signed(i_h0)) * NB_PROD'($signed(x0));
    assign prod1_c = NB_PROD'($signed(i_h1)) * NB_PROD'($signed(x1));
    assign prod2_c = NB_PROD'($signed(i_h2)) * NB_PROD'($signed(x2));

    SatTruncFP #(.NB_XI(NB_PROD), .NBF_XI(NBF_PROD), .NB_XO(NB_DATA), .NBF_XO(NBF_DATA))
        u_sat_p0 (.i_data(prod0_c), .o_data_c(p0_c));
    SatTruncFP #(.NB_XI(NB_PROD), .NBF_XI(NBF_PROD), .NB_XO(NB_DATA), .NBF_XO(NBF_DATA))
        u_sat_p1 (.i_data(prod1_c), .o_data_c(p1_c));
    SatTruncFP #(.NB_XI(NB_PROD), .NBF_XI(NBF_PROD), .NB_XO(NB_DATA), .NBF_XO(NBF_DATA))
        u_sat_p2 (.i_data(prod2_c), .o_data_c(p2_c));

    assign sum_c = NB_SUM'(p0_c) + NB_SUM'(p1_c) + NB_SUM'(p2_c);

    SatTruncFP #(.NB_XI(NB_SUM), .NBF_XI(NBF_DATA), .NB_XO(NB_DATA), .NBF_XO(NBF_DATA))
        u_sat_y (.i_data(sum_c), .o_data_c(y_c));

`ifdef LMS_DD_EN
    // Slicer: y >= 0 decides +1.0, otherwise -1.0.
    assign d_sel_c = mode_dd_s1 ? (y_c[NB_DATA-1] ? MINUS_ONE_Q16 : ONE_Q16) : d_s1;
`else
    assign d_sel_c = d_s1;
`endif

    assign err_c = NB_ERR'($signed(d_sel_c)) - NB_ERR'(y_c);

    SatTruncFP #(.NB_XI(NB_ERR), .NBF_XI(NBF_DATA), .NB_XO(NB_DATA), .NBF_XO(NBF_DATA))
        u_sat_e (.i_data(err_c), .o_data_c(err_sat_c));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_FILL;
            fill_cnt   <= '0;
            train_cnt  <= '0;
            x0         <= '0;
            x1         <= '0;
            x2         <= '0;
            d_s1       <= '0;
            live_s1    <= 1'b0;
            valid_s1   <= 1'b0;
`ifdef LMS_DD_EN
            mode_dd_s1 <= 1'b0;
`endif
            o_x0       <= '0;
            o_x1       <= '0;
            o_x2       <= '0;
            o_y        <= '0;
            o_error    <= '0;
            o_valid    <= 1'b0;
        end else if (i_restart) begin
            // Restart beats a coincident sample and drops anything in flight.
            state      <= ST_FILL;
            fill_cnt   <= '0;
            train_cnt  <= '0;
            x0         <= '0;
            x1         <= '0;
            x2         <= '0;
            live_s1    <= 1'b0;
            valid_s1   <= 1'b0;
`ifdef LMS_DD_EN
            mode_dd_s1 <= 1'b0;
`endif
            o_error    <= '0;
            o_valid    <= 1'b0;
        end else begin
            valid_s1 <= i_valid;
            if (i_valid) begin
                x2      <= x1;
                x1      <= x0;
                x0      <= i_x;
                d_s1    <= i_desired;
                live_s1 <= (state != ST_FILL);
`ifdef LMS_DD_EN
                mode_dd_s1 <= (state == ST_DD);
`endif
            end

            case (state)
                ST_FILL: begin
                    if (i_valid) begin
                        fill_cnt <= fill_cnt + 2'd1;
                        if (fill_cnt == 2'd1) state <= ST_TRAIN;
                    end
                end
                ST_TRAIN: begin
                    train_cnt <= train_nxt_c;
`ifdef LMS_DD_EN
                    if ((i_train_len != '0) && (train_nxt_c == i_train_len)) state <= ST_DD;
`endif
                end
                default: ;
            endcase

            o_valid <= valid_s1;
            o_error <= '0;
            if (valid_s1) begin
                o_y  <= y_c;
                o_x0 <= x0;
                o_x1 <= x1;
                o_x2 <= x2;
                if (live_s1) o_error <= err_sat_c;
            end
        end
    end

endmodule

// File: tb/tb_lms_fir_datapath.sv
// Scoreboard bench for lms_fir_datapath: driver pushes model results, negedge monitor pops and compares.
// Honours LMS_DD_EN in its reference model.
module tb_lms_fir_datapath;

    typedef struct packed {
        logic [31:0] y;
        logic [31:0] e;
        logic [31:0] x0;
        logic [31:0] x1;
        logic [31:0] x2;
    } exp_t;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_restart = 1'b0;
    logic        i_valid = 1'b0;
    logic [31:0] i_x = '0, i_desired = '0;
    logic [15:0] i_train_len = '0;
    logic [31:0] i_h0 = '0, i_h1 = '0, i_h2 = '0;
    logic [31:0] o_x0, o_x1, o_x2, o_error, o_y;
    logic        o_valid;
    logic [1:0]  o_state;

    lms_fir_datapath dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_restart(i_restart), .i_valid(i_valid),
        .i_x(i_x), .i_desired(i_desired), .i_train_len(i_train_len),
        .i_h0(i_h0), .i_h1(i_h1), .i_h2(i_h2),
        .o_x0(o_x0), .o_x1(o_x1), .o_x2(o_x2), .o_error(o_error), .o_y(o_y),
        .o_valid(o_valid), .o_state(o_state)
    );

    always #5 i_clk = ~i_clk;

    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    exp_t        q[$];
    logic [31:0] m_x0, m_x1, m_x2;
    int          m_fill, m_state;
    logic [15:0] m_train;
    bit          s1_pend, exp_ov;
    exp_t        hold;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
        end
    endtask

    function automatic longint sat32(input longint v);
        if (v > SMAX) return SMAX;
        if (v < SMIN) return SMIN;
        return v;
    endfunction

    // Q16.16 product: full product, floor away 16 bits, clamp to 32 bits.
    function automatic longint qmul(input logic [31:0] h, input logic [31:0] x);
        longint p;
        p = longint'($signed(h)) * longint'($signed(x));
        return sat32(p >>> 16);
    endfunction

    function automatic logic [31:0] rnd_word();
        logic [17:0] s;
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: begin
                s = 18'($urandom);
                return {{14{s[17]}}, s};
            end
            2: return ($urandom_range(0, 1) != 0) ? 32'h0001_0000 : 32'hFFFF_0000;
            default: return ($urandom_range(0, 1) != 0) ? 32'h7FFF_0000 : 32'h8000_0000;
        endcase
    endfunction

    task automatic clear_model();
        m_x0 = '0; m_x1 = '0; m_x2 = '0;
        m_fill = 0; m_train = '0; m_state = 0;
        s1_pend = 1'b0; exp_ov = 1'b0;
        q.delete();
        hold = '0;
    endtask

    // One clock of stimulus; the model predicts what the filter must produce for it.
    task automatic tick(input bit v, input bit r, input logic [31:0] x, input logic [31:0] d);
        exp_t   ex;
        longint y, dsel, e;
        int     nstate;
        i_valid = v; i_restart = r; i_x = x; i_desired = d;
        nstate = m_state;
        if (r) begin
            if (s1_pend) ex = q.pop_back();
            m_x0 = '0; m_x1 = '0; m_x2 = '0;
            m_fill = 0; m_train = '0; nstate = 0;
        end else begin
            if (v) begin
                m_x2 = m_x1; m_x1 = m_x0; m_x0 = x;
                y = sat32(qmul(i_h0, m_x0) + qmul(i_h1, m_x1) + qmul(i_h2, m_x2));
                if (m_state == 2) dsel = (y >= 0) ? 64'sd65536 : -64'sd65536;
                else              dsel = longint'($signed(d));
                e = sat32(dsel - y);
                ex.y  = 32'(y);
                ex.e  = (m_state != 0) ? 32'(e) : 32'h0;
                ex.x0 = m_x0; ex.x1 = m_x1; ex.x2 = m_x2;
                q.push_back(ex);
                if (m_state == 0) begin
                    m_fill++;
                    if (m_fill == 2) nstate = 1;
                end else if (m_state == 1) begin
                    m_train++;
                end
            end
`ifdef LMS_DD_EN
            if (m_state == 1 && i_train_len != 16'd0 && m_train == i_train_len) nstate = 2;
`endif
        end
        @(posedge i_clk);
        #1;
        exp_ov  = r ? 1'b0 : s1_pend;
        s1_pend = v && !r;
        m_state = nstate;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, $urandom, $urandom);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        i_rst = 1'b1; i_valid = 1'b0; i_restart = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        clear_model();
        mon_en = 1'b1;
    endtask

    task automatic set_h(input logic [31:0] h0, input logic [31:0] h1, input logic [31:0] h2);
        i_h0 = h0; i_h1 = h1; i_h2 = h2;
    endtask

    // Monitor: every cycle checks valid/state, pops on o_valid, otherwise checks idle behaviour.
    always @(negedge i_clk) begin
        exp_t ex;
        if (mon_en) begin
            chk("o_valid", 32'(o_valid), 32'(exp_ov));
            chk("o_state", 32'(o_state), 32'(m_state));
            if (o_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output at %0t: actual=o_valid required=no output", $time);
                end else begin
                    ex = q.pop_front();
                    chk("o_y", o_y, ex.y);
                    chk("o_error", o_error, ex.e);
                    chk("o_x0", o_x0, ex.x0);
                    chk("o_x1", o_x1, ex.x1);
                    chk("o_x2", o_x2, ex.x2);
                    hold = ex;
                end
            end else begin
                chk("o_error_idle", o_error, 32'h0);
                chk("o_y_hold", o_y, hold.y);
                chk("o_x0_hold", o_x0, hold.x0);
                chk("o_x2_hold", o_x2, hold.x2);
            end
        end
    end

    initial begin
        clear_model();
        do_reset();

        // Identity filter through fill and into training.
        set_h(32'h0001_0000, 32'h0, 32'h0);
        repeat (8) tick(1'b1, 1'b0, 32'h0002_0000, 32'h0002_0000);
        idle(3);

        // Half gain: y = 0.5, e = 0.5.
        set_h(32'h0000_8000, 32'h0, 32'h0);
        repeat (6) tick(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
        idle(3);

        // Product, sum and error saturation.
        set_h(32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000);
        repeat (5) tick(1'b1, 1'b0, 32'h7FFF_0000, 32'h8000_0000);
        idle(3);

        // Restart coincident with a sample mid-stream.
        set_h(rnd_word(), rnd_word(), rnd_word());
        repeat (4) tick(1'b1, 1'b0, rnd_word(), rnd_word());
        tick(1'b1, 1'b1, rnd_word(), rnd_word());
        repeat (5) tick(1'b1, 1'b0, rnd_word(), rnd_word());
        idle(3);

        // Short training then decision-directed with y = -0.25.
        i_train_len = 16'd4;
        tick(1'b0, 1'b1, 32'h0, 32'h0);
        set_h(32'hFFFF_C000, 32'h0, 32'h0);
        repeat (12) tick(1'b1, 1'b0, 32'h0001_0000, $urandom);
        idle(3);

        // Gapped valid, one on / two off.
        i_train_len = 16'd0;
        tick(1'b0, 1'b1, 32'h0, 32'h0);
        set_h(rnd_word(), rnd_word(), rnd_word());
        repeat (10) begin
            tick(1'b1, 1'b0, rnd_word(), rnd_word());
            idle(2);
        end
        idle(3);

        // Randomised segments with random train length and occasional restart.
        repeat (8) begin
            i_train_len = 16'($urandom_range(0, 6));
            if ($urandom_range(0, 1) != 0) tick(1'b0, 1'b1, 32'h0, 32'h0);
            set_h(rnd_word(), rnd_word(), rnd_word());
            repeat (40) tick($urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0,
                             rnd_word(), rnd_word());
            idle(3);
        end

        // Reset while samples are in flight.
        repeat (3) tick(1'b1, 1'b0, rnd_word(), rnd_word());
        do_reset();
        idle(3);
        set_h(32'h0001_0000, 32'h0000_8000, 32'hFFFF_8000);
        repeat (6) tick(1'b1, 1'b0, rnd_word(), rnd_word());
        idle(4);

        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
